// File: rtl/readout_pkg.sv
// Shared readout definitions: record field widths, packer FSM encoding and
// constants common to the hit packer and the Data_Switch stage.
package readout_pkg;

    localparam int HIT_W = 12;
    localparam int HDR_W = 24;
    localparam int REC_W = 36;

    localparam logic [HIT_W-1:0] PAD_WORD_DEFAULT = 12'hFFF;
    localparam logic [HIT_W-1:0] HDR_TRAILER      = 12'hEC5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_COLLECT = 2'd2,
        ST_EMIT    = 2'd3
    } pk_state_e;

endpackage

// File: rtl/hit_word_packer.sv
// Packs 12-bit hit words into header + 3-slot data records for the readout FIFO.
// Optional per-event hit limit with truncation flag: define EVENT_HIT_LIMIT_EN.
module hit_word_packer
    import readout_pkg::*;
#(
    parameter logic [HIT_W-1:0] PAD_WORD = PAD_WORD_DEFAULT,
    parameter logic [7:0]       MAX_HITS = 8'd255
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             EvStart,
    input  logic [HDR_W-1:0] EvHeader,
    input  logic             EvEmpty,
    output logic             EvReady,
    input  logic             HitValid,
    input  logic [HIT_W-1:0] HitWord,
    input  logic             HitLast,
    output logic             HitReady,
    input  logic             Full,
    output logic             ID_nData,
    output logic [HIT_W-1:0] Word0,
    output logic [HIT_W-1:0] Word1,
    output logic [HIT_W-1:0] Word2,
    output logic [HDR_W-1:0] Header,
    output logic             winc_out,
    output logic             TruncFlag
);

    pk_state_e        state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic             last_q, last_d;
    logic             empty_q, empty_d;
    logic             trunc_q, trunc_d;
    logic [HDR_W-1:0] header_q, header_d;
    logic [HIT_W-1:0] slot_q [3];
    logic [HIT_W-1:0] slot_d [3];

    logic ev_ready_q, ev_ready_d;
    logic hit_ready_q, hit_ready_d;
    logic winc_q, winc_d;
    logic id_q, id_d;

    logic       ev_acc_s;
    logic       hit_acc_s;
    logic       hit_keep_s;
    logic [2:0] fill_s;

    assign ev_acc_s  = EvStart & ev_ready_q & (state_q == ST_IDLE);
    assign hit_acc_s = HitValid & hit_ready_q & (state_q == ST_COLLECT);
    assign fill_s    = hit_keep_s ? ({1'b0, idx_q} + 3'd1) : {1'b0, idx_q};

`ifdef EVENT_HIT_LIMIT_EN
    logic [7:0] cnt_q;

    // Accepted-hit counter; stops at MAX_HITS so later hits are dropped.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            cnt_q <= 8'd0;
        end else if (ev_acc_s) begin
            cnt_q <= 8'd0;
        end else if (hit_acc_s && hit_keep_s) begin
            cnt_q <= cnt_q + 8'd1;
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign hit_keep_s = (cnt_q < MAX_HITS);
`else
    assign hit_keep_s = 1'b1;
`endif

    // FSM state and packing datapath registers.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= 2'd0;
            last_q   <= 1'b0;
            empty_q  <= 1'b0;
            trunc_q  <= 1'b0;
            header_q <= {HDR_W{1'b0}};
            for (int j = 0; j < 3; j++) begin
                slot_q[j] <= {HIT_W{1'b0}};
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            empty_q  <= empty_d;
            trunc_q  <= trunc_d;
            header_q <= header_d;
            slot_q   <= slot_d;
        end
    end

    // Next-state and slot-fill logic.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        last_d   = last_q;
        empty_d  = empty_q;
        trunc_d  = trunc_q;
        header_d = header_q;
        slot_d   = slot_q;
        case (state_q)
            ST_IDLE: begin
                if (ev_acc_s) begin
                    header_d = EvHeader;
                    empty_d  = EvEmpty;
                    idx_d    = 2'd0;
                    last_d   = 1'b0;
                    trunc_d  = 1'b0;
                    state_d  = ST_HDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (!Full) begin
                    state_d = empty_q ? ST_IDLE : ST_COLLECT;
                end else begin
                    state_d = ST_HDR;
                end
            end
            ST_COLLECT: begin
                if (hit_acc_s) begin
                    // A dropped hit carrying HitLast still pads from the current slot.
                    for (int j = 0; j < 3; j++) begin
                        if (hit_keep_s && (3'(j) == {1'b0, idx_q})) begin
                            slot_d[j] = HitWord;
                        end else if (HitLast && (3'(j) >= fill_s)) begin
                            slot_d[j] = PAD_WORD;
                        end else begin
                            slot_d[j] = slot_q[j];
                        end
                    end
                    if (hit_keep_s) begin
                        idx_d = idx_q + 2'd1;
                    end else begin
                        trunc_d = 1'b1;
                    end
                    if (HitLast) begin
                        last_d  = 1'b1;
                        state_d = (!hit_keep_s && (idx_q == 2'd0)) ? ST_IDLE : ST_EMIT;
                    end else if (hit_keep_s && (idx_q == 2'd2)) begin
                        state_d = ST_EMIT;
                    end else begin
                        state_d = ST_COLLECT;
                    end
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            ST_EMIT: begin
                if (!Full) begin
                    if (last_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_COLLECT;
                        idx_d   = 2'd0;
                    end
                end else begin
                    state_d = ST_EMIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so handshakes come straight off flops.
    always_comb begin
        ev_ready_d  = 1'b0;
        hit_ready_d = 1'b0;
        winc_d      = 1'b0;
        id_d        = 1'b0;
        case (state_d)
            ST_IDLE: begin
                ev_ready_d = 1'b1;
            end
            ST_HDR: begin
                winc_d = 1'b1;
                id_d   = 1'b1;
            end
            ST_COLLECT: begin
                hit_ready_d = 1'b1;
            end
            ST_EMIT: begin
                winc_d = 1'b1;
            end
            default: begin
                ev_ready_d = 1'b0;
            end
        endcase
    end

    // Handshake and record-control output registers.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            ev_ready_q  <= 1'b0;
            hit_ready_q <= 1'b0;
            winc_q      <= 1'b0;
            id_q        <= 1'b0;
        end else begin
            ev_ready_q  <= ev_ready_d;
            hit_ready_q <= hit_ready_d;
            winc_q      <= winc_d;
            id_q        <= id_d;
        end
    end

    assign EvReady   = ev_ready_q;
    assign HitReady  = hit_ready_q;
    assign winc_out  = winc_q;
    assign ID_nData  = id_q;
    assign Header    = header_q;
    assign Word0     = slot_q[0];
    assign Word1     = slot_q[1];
    assign Word2     = slot_q[2];
    assign TruncFlag = trunc_q;

endmodule

// File: tb/tb_hit_word_packer.sv
// Bench for hit_word_packer: directed scenarios plus randomized events and
// Full back-pressure, checked against an event-level record model.
module tb_hit_word_packer;
    import readout_pkg::*;

    localparam logic [11:0] PAD = 12'hFFF;
`ifdef EVENT_HIT_LIMIT_EN
    localparam int MAXH = 4;
`else
    localparam int MAXH = 255;
`endif

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        EvStart = 1'b0;
    logic [23:0] EvHeader = 24'h0;
    logic        EvEmpty = 1'b0;
    logic        EvReady;
    logic        HitValid = 1'b0;
    logic [11:0] HitWord = 12'h0;
    logic        HitLast = 1'b0;
    logic        HitReady;
    logic        Full = 1'b0;
    logic        ID_nData;
    logic [11:0] Word0, Word1, Word2;
    logic [23:0] Header;
    logic        winc_out;
    logic        TruncFlag;

    hit_word_packer #(.PAD_WORD(PAD), .MAX_HITS(8'(MAXH))) dut (
        .Clk(Clk), .Reset(Reset), .EvStart(EvStart), .EvHeader(EvHeader),
        .EvEmpty(EvEmpty), .EvReady(EvReady), .HitValid(HitValid),
        .HitWord(HitWord), .HitLast(HitLast), .HitReady(HitReady), .Full(Full),
        .ID_nData(ID_nData), .Word0(Word0), .Word1(Word1), .Word2(Word2),
        .Header(Header), .winc_out(winc_out), .TruncFlag(TruncFlag)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        id;
        logic [23:0] hdr;
        logic [35:0] words;
        logic        chk_tr;
        logic        tr;
    } rec_t;

    rec_t        exp_q[$];
    logic [11:0] hw[$];
    int n_checks = 0;
    int n_fail   = 0;
    int taken    = 0;
    int pushed   = 0;
    logic mon_en = 1'b0;
    logic rand_full_en = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Event-level model: header record, then hits chunked by three with padding.
    task automatic push_expect(input logic [23:0] hdr);
        rec_t r;
        int n, kept, nrec;
        logic tr;
        logic [11:0] w [3];
        n = hw.size();
        kept = (n > MAXH) ? MAXH : n;
        tr = (n > MAXH);
        r.id = 1'b1; r.hdr = hdr; r.words = 36'h0; r.chk_tr = 1'b1; r.tr = 1'b0;
        exp_q.push_back(r);
        pushed++;
        nrec = (kept + 2) / 3;
        for (int rr = 0; rr < nrec; rr++) begin
            for (int s = 0; s < 3; s++) begin
                w[s] = (3 * rr + s < kept) ? hw[3 * rr + s] : PAD;
            end
            r.id = 1'b0;
            r.words = {w[0], w[1], w[2]};
            r.chk_tr = (rr == nrec - 1) && !(tr && (kept % 3 == 0));
            r.tr = tr;
            exp_q.push_back(r);
            pushed++;
        end
    endtask

    task automatic start_event(input logic [23:0] hdr, input logic empty);
        int t;
        for (t = 0; t < 300 && !EvReady; t++) begin
            @(posedge Clk); #1;
        end
        if (t >= 300) check_eq("evready_timeout", 64'd0, 64'd1);
        EvStart = 1'b1; EvHeader = hdr; EvEmpty = empty;
        @(posedge Clk); #1;
        EvStart = 1'b0; EvEmpty = 1'b0;
    endtask

    task automatic send_hit(input logic [11:0] w, input logic last);
        int t;
        logic acc;
        HitValid = 1'b1; HitWord = w; HitLast = last;
        acc = 1'b0;
        for (t = 0; t < 300 && !acc; t++) begin
            acc = HitReady;
            @(posedge Clk); #1;
        end
        if (!acc) check_eq("hit_timeout", 64'd0, 64'd1);
        HitValid = 1'b0; HitLast = 1'b0;
    endtask

    task automatic run_event(input logic [23:0] hdr, input logic gaps);
        int n;
        n = hw.size();
        push_expect(hdr);
        start_event(hdr, (n == 0));
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge Clk); #1; end
            send_hit(hw[i], (i == n - 1));
        end
    endtask

    task automatic wait_idle();
        int t;
        for (t = 0; t < 500 && (exp_q.size() != 0 || !EvReady); t++) begin
            @(posedge Clk); #1;
        end
        if (t >= 500) check_eq("idle_timeout", 64'd0, 64'd1);
    endtask

    // Random back-pressure while enabled.
    always @(posedge Clk) begin
        if (rand_full_en) begin
            #1;
            Full = ($urandom_range(0, 2) == 0);
        end
    end

    logic        hold_v = 1'b0;
    logic        snap_id;
    logic [35:0] snap_w;
    logic [23:0] snap_h;

    // Record monitor: scoreboard on taken records, hold check while Full stalls.
    always @(negedge Clk) begin
        rec_t r;
        if (mon_en) begin
            if (hold_v) begin
                check_eq("hold_winc", winc_out, 1'b1);
                check_eq("hold_id", ID_nData, snap_id);
                check_eq("hold_words", {Word0, Word1, Word2}, snap_w);
                check_eq("hold_hdr", Header, snap_h);
            end
            hold_v = 1'b0;
            if (winc_out) begin
                if (Full) begin
                    hold_v = 1'b1; snap_id = ID_nData;
                    snap_w = {Word0, Word1, Word2}; snap_h = Header;
                end else begin
                    taken++;
                    if (exp_q.size() == 0) begin
                        check_eq("spurious_rec", 64'd1, 64'd0);
                    end else begin
                        r = exp_q.pop_front();
                        check_eq("rec_id", ID_nData, r.id);
                        check_eq("rec_hdr", Header, r.hdr);
                        if (!r.id) check_eq("rec_words", {Word0, Word1, Word2}, r.words);
                        if (r.chk_tr) check_eq("rec_trunc", TruncFlag, r.tr);
                    end
                end
            end
        end
    end

    initial begin
        int t0;
        // Reset state
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check_eq("rst_winc", winc_out, 1'b0);
        check_eq("rst_id", ID_nData, 1'b0);
        check_eq("rst_evready", EvReady, 1'b0);
        check_eq("rst_hitready", HitReady, 1'b0);
        check_eq("rst_trunc", TruncFlag, 1'b0);
        check_eq("rst_words", {Word0, Word1, Word2}, 36'h0);
        check_eq("rst_hdr", Header, 24'h0);
        @(posedge Clk); #1;
        Reset = 1'b1;
        @(negedge Clk);
        check_eq("evready_first_cycle", EvReady, 1'b0);
        @(posedge Clk); #1;
        check_eq("evready_after_rel", EvReady, 1'b1);
        mon_en = 1'b1;

        // Zero-hit event
        hw.delete();
        run_event(24'hA50123, 1'b0);
        check_eq("empty_hdr_winc", winc_out, 1'b1);
        check_eq("empty_hdr_id", ID_nData, 1'b1);
        check_eq("empty_hdr_val", Header, 24'hA50123);
        @(posedge Clk); #1;
        check_eq("empty_winc_drop", winc_out, 1'b0);
        check_eq("empty_evready", EvReady, 1'b1);

        // Three hits
        hw = '{12'h001, 12'h002, 12'h003};
        run_event(24'h000111, 1'b0);
        check_eq("emit_latency", winc_out, 1'b1);
        check_eq("emit_id", ID_nData, 1'b0);
        check_eq("emit_words", {Word0, Word1, Word2}, 36'h001002003);
        wait_idle();

        // Four hits
        hw = '{12'h00A, 12'h00B, 12'h00C, 12'h00D};
        run_event(24'h000222, 1'b0);
        wait_idle();

        // Full stall on EMIT
        hw = '{12'h011, 12'h022, 12'h033};
        run_event(24'h000333, 1'b0);
        Full = 1'b1;
        repeat (5) begin
            check_eq("stall_words", {Word0, Word1, Word2}, 36'h011022033);
            check_eq("stall_winc", winc_out, 1'b1);
            @(posedge Clk); #1;
        end
        t0 = taken;
        Full = 1'b0;
        @(posedge Clk); #1;
        check_eq("stall_one_taken", taken, t0 + 1);
        check_eq("stall_done_winc", winc_out, 1'b0);
        wait_idle();

        // Reset mid-event
        hw.delete();
        push_expect(24'h0BAD01);
        start_event(24'h0BAD01, 1'b0);
        send_hit(12'h005, 1'b0);
        send_hit(12'h006, 1'b0);
        Reset = 1'b0;
        @(posedge Clk); #1;
        Reset = 1'b1;
        check_eq("midrst_winc", winc_out, 1'b0);
        check_eq("midrst_words", {Word0, Word1, Word2}, 36'h0);
        check_eq("midrst_hdr", Header, 24'h0);
        check_eq("midrst_hitready", HitReady, 1'b0);
        check_eq("midrst_evready", EvReady, 1'b0);
        @(posedge Clk); #1;
        check_eq("midrst_idle", EvReady, 1'b1);
        check_eq("midrst_flushed", exp_q.size(), 0);
        hw = '{12'h123, 12'h456};
        run_event(24'h0BAD02, 1'b0);
        wait_idle();

`ifdef EVENT_HIT_LIMIT_EN
        // Truncation with MAX_HITS=4
        hw = '{12'h101, 12'h102, 12'h103, 12'h104, 12'h105, 12'h106, 12'h107};
        run_event(24'h7E7E01, 1'b0);
        wait_idle();
        repeat (3) @(posedge Clk); #1;
        check_eq("trunc_sticky", TruncFlag, 1'b1);
`endif

        // Randomized events with back-pressure
        rand_full_en = 1'b1;
        for (int e = 0; e < 30; e++) begin
            int n;
            n = $urandom_range(0, 9);
            hw.delete();
            for (int i = 0; i < n; i++) hw.push_back(12'($urandom));
            run_event(24'($urandom), 1'b1);
        end
        rand_full_en = 1'b0;
        @(posedge Clk); #2;
        Full = 1'b0;
        wait_idle();
        check_eq("drain_empty", exp_q.size(), 0);
        check_eq("rec_total", taken, pushed);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
